// File: rtl/life_cell_engine_pkg.sv
// Shared types and constants for the Game of Life cell engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } life_state_t;

  localparam int COUNT_W = 4;

  // Entry k is the window bit summed on the k-th accumulate cycle; the centre (bit 4) is skipped.
  localparam logic [7:0][3:0] NEIGHBOR_IDX = {4'd8, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0};

  localparam logic [8:0] DEFAULT_BIRTH_MASK   = 9'b0_0000_1000;
  localparam logic [8:0] DEFAULT_SURVIVE_MASK = 9'b0_0000_1100;

endpackage

// File: rtl/life_cell_engine_if.sv
// Window-in / next-state-out handshake bundle for life_cell_engine.
// COUNT is carried only when LIFE_COUNT_OUT_EN is defined.
interface life_cell_engine_if;
  import life_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [8:0]         window;
  logic               out_valid;
  logic               out_ready;
  logic               next_state;
`ifdef LIFE_COUNT_OUT_EN
  logic [COUNT_W-1:0] count;
`endif

  modport slave (
    input  in_valid, window, out_ready,
    output in_ready, out_valid, next_state
`ifdef LIFE_COUNT_OUT_EN
    , output count
`endif
  );

  modport master (
    output in_valid, window, out_ready,
    input  in_ready, out_valid, next_state
`ifdef LIFE_COUNT_OUT_EN
    , input count
`endif
  );

endinterface

// File: rtl/life_cell_engine_count_incrementer.sv
// Ripple incrementer: value + inc_i through a chain of full adders (b inputs tied low).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module count_incrementer
  import life_pkg::*;
(
  input  logic [COUNT_W-1:0] value_i,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] sum_o
);
  logic [COUNT_W:0] carry;
  logic             unused_carry;

  assign carry[0] = inc_i;

  for (genvar g = 0; g < COUNT_W; g++) begin : g_fa
    full_adder u_fa (
      .a_i (value_i[g]),
      .b_i (1'b0),
      .c_i (carry[g]),
      .s_o (sum_o[g]),
      .c_o (carry[g+1])
    );
  end

  // Count never exceeds 8, so the top carry cannot be set.
  assign unused_carry = carry[COUNT_W];
endmodule

// File: rtl/life_cell_engine.sv
// Serial next-state engine for one Life cell: sums 8 neighbours one per cycle, then applies B/S masks.
// Optional macro LIFE_COUNT_OUT_EN exposes the registered final neighbour count on the interface.
module life_cell_engine
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = DEFAULT_BIRTH_MASK,
  parameter logic [8:0] SURVIVE_MASK = DEFAULT_SURVIVE_MASK
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  life_cell_engine_if.slave  cell_if
);

  life_state_t        state_q, state_d;
  logic [8:0]         win_q, win_d;
  logic [COUNT_W-1:0] acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic               ns_q, ns_d;
  logic               vld_q, vld_d;
  logic [COUNT_W-1:0] sum;
`ifdef LIFE_COUNT_OUT_EN
  logic [COUNT_W-1:0] cnt_out_q, cnt_out_d;
`endif

  count_incrementer u_inc (
    .value_i (acc_q),
    .inc_i   (win_q[NEIGHBOR_IDX[idx_q]]),
    .sum_o   (sum)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      win_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      ns_q      <= 1'b0;
      vld_q     <= 1'b0;
`ifdef LIFE_COUNT_OUT_EN
      cnt_out_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      ns_q      <= ns_d;
      vld_q     <= vld_d;
`ifdef LIFE_COUNT_OUT_EN
      cnt_out_q <= cnt_out_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ns_d      = ns_q;
    vld_d     = vld_q;
`ifdef LIFE_COUNT_OUT_EN
    cnt_out_d = cnt_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (cell_if.in_valid) begin
          win_d   = cell_if.window;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + 3'd1;
        // The eighth add feeds the rule directly so the result lands on the same edge.
        if (idx_q == 3'd7) begin
          ns_d      = win_q[4] ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];
          vld_d     = 1'b1;
          state_d   = DONE;
`ifdef LIFE_COUNT_OUT_EN
          cnt_out_d = sum;
`endif
        end
      end
      DONE: begin
        if (cell_if.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cell_if.in_ready   = (state_q == IDLE);
  assign cell_if.out_valid  = vld_q;
  assign cell_if.next_state = ns_q;
`ifdef LIFE_COUNT_OUT_EN
  assign cell_if.count      = cnt_out_q;
`endif

endmodule

// File: tb/tb_life_cell_engine.sv
// Directed bench for life_cell_engine: default-rule and HighLife instances driven in lockstep.
module tb_life_cell_engine;
  import life_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [8:0] window = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  life_cell_engine_if if_def();
  life_cell_engine_if if_hl();

  assign if_def.in_valid  = in_valid;
  assign if_def.window    = window;
  assign if_def.out_ready = out_ready;
  assign if_hl.in_valid   = in_valid;
  assign if_hl.window     = window;
  assign if_hl.out_ready  = out_ready;

  life_cell_engine u_def (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cell_if (if_def)
  );

  life_cell_engine #(
    .BIRTH_MASK   (9'b0_0100_1000),
    .SURVIVE_MASK (9'b0_0000_1100)
  ) u_hl (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cell_if (if_hl)
  );

  typedef struct {
    logic [8:0] win;
    logic       ns;
    logic       ns_hl;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents w once IN_READY is seen; returns #1 after the accept edge.
  task automatic send(input logic [8:0] w);
    int n = 0;
    @(negedge clk);
    while (!if_def.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", if_def.in_ready, 1);
    in_valid = 1'b1;
    window   = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!if_def.out_valid && lat < 30);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("drain_in_ready", if_def.in_ready, 1);
    check("drain_out_valid", if_def.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{9'b000_111_000, 1'b1, 1'b1, 4'd2};
    vecs[1] = '{9'b100_000_011, 1'b1, 1'b1, 4'd3};
    vecs[2] = '{9'b100_000_001, 1'b0, 1'b0, 4'd2};
    vecs[3] = '{9'b111_111_111, 1'b0, 1'b0, 4'd8};
    vecs[4] = '{9'b000_010_000, 1'b0, 1'b0, 4'd0};
    vecs[5] = '{9'b000_010_111, 1'b1, 1'b1, 4'd3};
    vecs[6] = '{9'b001_010_111, 1'b0, 1'b0, 4'd4};
    vecs[7] = '{9'b111_101_111, 1'b0, 1'b0, 4'd8};
    vecs[8] = '{9'b100_010_000, 1'b0, 1'b0, 4'd1};
    vecs[9] = '{9'b111_000_111, 1'b0, 1'b1, 4'd6};

    #1;
    check("reset_in_ready", if_def.in_ready, 1);
    check("reset_out_valid", if_def.out_valid, 0);
    check("reset_next_state", if_def.next_state, 0);
`ifdef LIFE_COUNT_OUT_EN
    check("reset_count", if_def.count, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].win);
      check("accept_in_ready_low", if_def.in_ready, 0);
      wait_out(lat);
      check("latency", lat, 8);
      check("next_state", if_def.next_state, vecs[i].ns);
      check("hl_out_valid", if_hl.out_valid, 1);
      check("hl_next_state", if_hl.next_state, vecs[i].ns_hl);
`ifdef LIFE_COUNT_OUT_EN
      check("count", if_def.count, vecs[i].cnt);
`endif
      drain();
    end

    // Backpressure in DONE with a busy upstream.
    send(9'b100_000_011);
    wait_out(lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      window   = (i % 2 == 1) ? 9'b000_010_000 : 9'b000_111_000;
      @(posedge clk);
      #1;
      check("bp_out_valid", if_def.out_valid, 1);
      check("bp_next_state", if_def.next_state, 1);
      check("bp_in_ready", if_def.in_ready, 0);
`ifdef LIFE_COUNT_OUT_EN
      check("bp_count", if_def.count, 3);
`endif
    end
    window    = 9'b111_111_111;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_in_ready", if_def.in_ready, 1);
    check("bp_release_out_valid", if_def.out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_accept", if_def.in_ready, 0);
    wait_out(lat);
    check("bp_next_latency", lat, 8);
    check("bp_next_state2", if_def.next_state, 0);
`ifdef LIFE_COUNT_OUT_EN
    check("bp_count2", if_def.count, 8);
`endif
    drain();
`ifdef LIFE_COUNT_OUT_EN
    check("count_held_after_drain", if_def.count, 8);
`endif

    // Reset mid-accumulation.
    send(9'b000_111_000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_accum_in_ready", if_def.in_ready, 1);
    check("rst_accum_out_valid", if_def.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(9'b000_111_000);
    wait_out(lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_next_state", if_def.next_state, 1);

    // Reset while holding a result in DONE.
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", if_def.out_valid, 0);
    check("rst_done_next_state", if_def.next_state, 0);
    check("rst_done_in_ready", if_def.in_ready, 1);
`ifdef LIFE_COUNT_OUT_EN
    check("rst_done_count", if_def.count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
